src_fwd_unit: RTL
=================

# src_fwd_unit

Parametrised operand-select and forwarding unit for ALU source 1, placed between decode (ID) and execute (EX). It tracks in-flight register writes in an internal tag pipeline, compares tags itself instead of relying on a decoder-supplied forwarding select, and raises a load-use stall when needed. The selected operands are registered into EX.

## Interface
Parameters:
- WIDTH, 16, datapath width; at least 9.
- RADDR, 4, register address width; register 0 is hardwired zero.
- FWD_DEPTH, 2, number of forwarding stages tracked (stage 0 = EX, 1 = MEM, ...); range 2..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_src_sel  in  2  operand source: 0 register, 1 imm8 sign-extended, 2 imm4 (imm[3:0]) sign-extended, 3 pc.
- id_src_reg  in  RADDR  source register address.
- id_reg_data  in  WIDTH  register file read value p1.
- id_imm  in  8  immediate field.
- id_pc  in  WIDTH  PC+1.
- id_dst_reg  in  RADDR  destination register of the ID instruction.
- id_dst_we  in  1  ID instruction writes id_dst_reg.
- id_is_load  in  1  ID instruction is a load; its result is valid only from stage 1.
- flush  in  1  branch flush; kills the ID instruction.
- fwd_data  in  FWD_DEPTH*WIDTH  stage i result at [i*WIDTH +: WIDTH].
- stall  out  1  combinational load-use stall to ID and the PC.
- ex_valid  out  1  registered; EX holds a valid instruction.
- ex_src1  out  WIDTH  registered ALU source 1.
- ex_shift_src1  out  WIDTH  registered shifter source (see Configuration).

## Operation
- Tag pipeline: FWD_DEPTH entries, each holding {v, we, load, dst}. Every cycle, entry i moves to entry i+1 and the last entry is discarded.
- Entry 0 load rule:
  - It loads the ID instruction's tag when issue = id_valid & ~stall & ~flush.
  - Otherwise it loads a bubble (v=0).
- Match for stage i: v & we & dst == id_src_reg & id_src_reg != 0 & id_src_sel == 0.
- Operand selection (raw src1):
  - Register source: the youngest matching stage (lowest i) supplies fwd_data stage i. With no match, id_reg_data is used.
  - Immediate sources: {{WIDTH-8{imm[7]}},imm} or {{WIDTH-4{imm[3]}},imm[3:0]}.
  - PC source: id_pc.
- Stall:
  - stall = id_valid & ~flush & stage0 match & stage0 load.
  - A load in stage 1 or later is forwarded normally and does not stall.
- Shifter source:
  - Register (with the same forwarding) or imm8.
  - Selects 2 and 3 produce the imm8 value.
- EX register update:
  - On issue: ex_valid=1, and ex_src1/ex_shift_src1 take the selected values.
  - On stall or flush: ex_valid=0, and the data registers hold their values.
- Simultaneous flush and stall: flush wins, stall=0, bubble inserted.
- Register 0 never matches, never stalls, and always reads id_reg_data.

## Timing
- Selection is combinational from ID inputs. EX outputs are visible one cycle after issue.
- Stall latency: exactly one bubble cycle for back-to-back load-use. In the next cycle the load is in stage 1 and is forwarded.
- Forwarding window: a producer issued k cycles earlier (1 ≤ k ≤ FWD_DEPTH) is in stage k-1. Producers older than FWD_DEPTH cycles must already be in the register file.
- Reset values: all tag entries v=0, ex_valid=0, ex_src1=0, ex_shift_src1=0. stall=0 while reset is asserted.
- Reset mid-operation clears all in-flight tags immediately and asynchronously. No stale forwarding occurs after deassertion.

## Configuration
- SRC_SHIFT_PATH_EN:
  - Defined: the ex_shift_src1 register and its parallel mux are built, which keeps the shifter off the full src1 mux path.
  - Undefined: ex_shift_src1 is tied to 0 and the shifter must use ex_src1. No logic is generated for it.

## Test plan
- ADD R3 issued, then next cycle a consumer reads R3 with id_reg_data=0x1111 and fwd_data stage0=0xBEEF -> ex_src1=0xBEEF, no stall.
- Producers of R5 two cycles and one cycle earlier (stage1=0x0002, stage0=0x0001) -> ex_src1=0x0001 (youngest wins).
- LW R4 followed by a consumer of R4 -> stall=1 for one cycle and ex_valid=0. The next cycle, with stage1=0x7777, gives ex_src1=0x7777 and stall=0.
- Immediates: imm=0x8A with sel 1 -> 0xFF8A; sel 2 -> 0xFFFA; sel 3 with id_pc=0x0042 -> 0x0042; ex_shift_src1=0xFF8A when the macro is defined.
- Load-use stall coincident with flush=1 -> stall=0, ex_valid=0 next cycle, and entry 0 holds a bubble.
- Reset asserted while a producer of R2 is in stage 0, then released; a consumer of R2 with id_reg_data=0x00AA -> ex_src1=0x00AA. R0 with a matching stage -> id_reg_data used.

Source files
------------

// File: rtl/src_fwd_unit_if.sv
// ID-to-EX bundle for the ALU source-1 forwarding unit: decode fields and stage results in,
// stall and registered EX operands out.
interface src_fwd_unit_if #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RADDR     = 4,
  parameter int unsigned FWD_DEPTH = 2
) ();

  logic                       id_valid;
  logic [1:0]                 id_src_sel;
  logic [RADDR-1:0]           id_src_reg;
  logic [WIDTH-1:0]           id_reg_data;
  logic [7:0]                 id_imm;
  logic [WIDTH-1:0]           id_pc;
  logic [RADDR-1:0]           id_dst_reg;
  logic                       id_dst_we;
  logic                       id_is_load;
  logic                       flush;
  logic [FWD_DEPTH*WIDTH-1:0] fwd_data;

  logic                       stall;
  logic                       ex_valid;
  logic [WIDTH-1:0]           ex_src1;
  logic [WIDTH-1:0]           ex_shift_src1;

  // Decode/pipeline side drives the ID fields and stage results.
  modport master (
    output id_valid, id_src_sel, id_src_reg, id_reg_data, id_imm, id_pc,
           id_dst_reg, id_dst_we, id_is_load, flush, fwd_data,
    input  stall, ex_valid, ex_src1, ex_shift_src1
  );

  modport slave (
    input  id_valid, id_src_sel, id_src_reg, id_reg_data, id_imm, id_pc,
           id_dst_reg, id_dst_we, id_is_load, flush, fwd_data,
    output stall, ex_valid, ex_src1, ex_shift_src1
  );

endinterface

// File: rtl/src_fwd_unit.sv
// ALU source-1 operand select with tag-based forwarding and load-use stall, registered into EX.
// Optional macro SRC_SHIFT_PATH_EN builds a separate registered shifter source.
module src_fwd_unit #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RADDR     = 4,
  parameter int unsigned FWD_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  src_fwd_unit_if.slave  bus
);

  if (WIDTH < 9) begin : gen_bad_width
    $error("src_fwd_unit: WIDTH must be at least 9");
  end
  if (FWD_DEPTH < 2 || FWD_DEPTH > 4) begin : gen_bad_depth
    $error("src_fwd_unit: FWD_DEPTH must be in 2..4");
  end

  typedef struct packed {
    logic             v;
    logic             we;
    logic             load;
    logic [RADDR-1:0] dst;
  } tag_t;

  tag_t             tag_q [FWD_DEPTH];
  tag_t             tag_d [FWD_DEPTH];

  logic [FWD_DEPTH-1:0] match;
  logic                 stall;
  logic                 issue;
  logic [WIDTH-1:0]     reg_fwd;
  logic [WIDTH-1:0]     imm8_ext;
  logic [WIDTH-1:0]     imm4_ext;
  logic [WIDTH-1:0]     src1_sel;

  logic                 ex_valid_q, ex_valid_d;
  logic [WIDTH-1:0]     ex_src1_q, ex_src1_d;

  // A stage matches only for a real register read of a nonzero register.
  always_comb begin
    for (int i = 0; i < FWD_DEPTH; i++) begin
      match[i] = tag_q[i].v & tag_q[i].we & (tag_q[i].dst == bus.id_src_reg) &
                 (bus.id_src_reg != '0) & (bus.id_src_sel == 2'd0);
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    reg_fwd = bus.id_reg_data;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        reg_fwd = bus.fwd_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign imm8_ext = {{(WIDTH-8){bus.id_imm[7]}}, bus.id_imm};
  assign imm4_ext = {{(WIDTH-4){bus.id_imm[3]}}, bus.id_imm[3:0]};

  always_comb begin
    src1_sel = bus.id_reg_data;
    unique case (bus.id_src_sel)
      2'd0:    src1_sel = reg_fwd;
      2'd1:    src1_sel = imm8_ext;
      2'd2:    src1_sel = imm4_ext;
      default: src1_sel = bus.id_pc;
    endcase
  end

  // Only a load still in EX is too young to forward; flush overrides the stall.
  assign stall     = bus.id_valid & ~bus.flush & match[0] & tag_q[0].load;
  assign issue     = bus.id_valid & ~stall & ~bus.flush;
  assign bus.stall = stall;

  always_comb begin
    tag_d[0] = '0;
    if (issue) begin
      tag_d[0].v    = 1'b1;
      tag_d[0].we   = bus.id_dst_we;
      tag_d[0].load = bus.id_is_load;
      tag_d[0].dst  = bus.id_dst_reg;
    end
    for (int i = 1; i < FWD_DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FWD_DEPTH; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Data registers hold across stall/flush bubbles; only ex_valid drops.
  always_comb begin
    ex_valid_d = issue;
    ex_src1_d  = issue ? src1_sel : ex_src1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_src1_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_src1_q  <= ex_src1_d;
    end
  end

  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_src1  = ex_src1_q;

`ifdef SRC_SHIFT_PATH_EN
  logic [WIDTH-1:0] shift_sel;
  logic [WIDTH-1:0] ex_shift_q, ex_shift_d;

  // Parallel two-way mux keeps the shifter off the full src1 selection path.
  always_comb begin
    shift_sel  = (bus.id_src_sel == 2'd0) ? reg_fwd : imm8_ext;
    ex_shift_d = issue ? shift_sel : ex_shift_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_shift_q <= '0;
    end else begin
      ex_shift_q <= ex_shift_d;
    end
  end

  assign bus.ex_shift_src1 = ex_shift_q;
`else
  assign bus.ex_shift_src1 = '0;
`endif

endmodule
